// File: rtl/battleship_pkg.sv
// Shared definitions for the Battleship game: grid size, datapath state codes, player IDs.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package battleship_pkg;

  localparam int CELLS = 36;

  // State codes presented on dp_state; hit_or_miss and the display decode these.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PLACE_P1  = 3'd1;
  localparam logic [2:0] ST_PLACE_P2  = 3'd2;
  localparam logic [2:0] ST_FIRE      = 3'd3;
  localparam logic [2:0] ST_RESULT    = 3'd4;
  localparam logic [2:0] ST_GAME_OVER = 3'd5;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  // Internal sequencer phases; FIRE is split into ARM and WAIT.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLACE_P1  = 3'd1,
    S_PLACE_P2  = 3'd2,
    S_FIRE_ARM  = 3'd3,
    S_FIRE_WAIT = 3'd4,
    S_RESULT    = 3'd5,
    S_GAME_OVER = 3'd6
  } phase_e;

  // Map internal phase to the externally visible state code.
  function automatic logic [2:0] state_code(input phase_e p);
    logic [2:0] c;
    c = ST_IDLE;
    case (p)
      S_IDLE:      c = ST_IDLE;
      S_PLACE_P1:  c = ST_PLACE_P1;
      S_PLACE_P2:  c = ST_PLACE_P2;
      S_FIRE_ARM:  c = ST_FIRE;
      S_FIRE_WAIT: c = ST_FIRE;
      S_RESULT:    c = ST_RESULT;
      S_GAME_OVER: c = ST_GAME_OVER;
      default:     c = ST_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/onehot_check.sv
// Combinational one-hot detector over a cell-select vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: vec (WIDTH-bit input), is_onehot (1 when exactly one bit of vec is set).
module onehot_check #(
  parameter int WIDTH = battleship_pkg::CELLS
) (
  input  logic [WIDTH-1:0] vec,
  output logic             is_onehot
);

  // Nonzero and clearing the lowest set bit leaves nothing behind.
  always_comb begin
    is_onehot = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/battleship_turn_controller.sv
// Game sequencer for two-player Battleship: placement, alternating fire turns, winner detect.
// Latency: key accept -> dp_fire 1 cycle; dp response -> board update 1 cycle; empty board -> winner_valid RESULT_HOLD+1.
// Backpressure: none; keys are accepted or rejected (err) immediately, datapath gets DP_TIMEOUT cycles to answer.
// Ports: clk/reset (sync, active-high); start; key_valid/key (one-hot cell); dp_hit/dp_miss/dp_new_ships from
//        datapath; dp_place/dp_fire/dp_state/dp_target/dp_enemy_ships to datapath; turn; p1/p2 boards and shot
//        masks; last_hit/last_miss; err pulse; winner_valid/winner.
module battleship_turn_controller
  import battleship_pkg::*;
#(
  parameter int CELLS             = battleship_pkg::CELLS,
  parameter int SHIP_CELLS        = 4,
  parameter int RESULT_HOLD       = 4,
  parameter int DP_TIMEOUT        = 8,
  parameter bit EXTRA_TURN_ON_HIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             key_valid,
  input  logic [CELLS-1:0] key,
  input  logic             dp_hit,
  input  logic             dp_miss,
  input  logic [CELLS-1:0] dp_new_ships,
  output logic             dp_place,
  output logic             dp_fire,
  output logic [2:0]       dp_state,
  output logic [CELLS-1:0] dp_target,
  output logic [CELLS-1:0] dp_enemy_ships,
  output logic             turn,
  output logic [CELLS-1:0] p1_board,
  output logic [CELLS-1:0] p2_board,
  output logic [CELLS-1:0] p1_shots,
  output logic [CELLS-1:0] p2_shots,
  output logic             last_hit,
  output logic             last_miss,
  output logic             err,
  output logic             winner_valid,
  output logic             winner
);

  localparam int PCW = (SHIP_CELLS  > 1) ? $clog2(SHIP_CELLS)  : 1;
  localparam int WCW = (DP_TIMEOUT  > 1) ? $clog2(DP_TIMEOUT)  : 1;
  localparam int HCW = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;

  phase_e           state_q, state_d;
  logic             turn_q, turn_d;
  logic [CELLS-1:0] p1_board_q, p1_board_d;
  logic [CELLS-1:0] p2_board_q, p2_board_d;
  logic [CELLS-1:0] p1_shots_q, p1_shots_d;
  logic [CELLS-1:0] p2_shots_q, p2_shots_d;
  logic [CELLS-1:0] target_q, target_d;
  logic [PCW-1:0]   placed_q, placed_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
  logic             last_hit_q, last_hit_d;
  logic             last_miss_q, last_miss_d;
  logic             err_q, err_d;
  logic             fire_q, fire_d;
  logic             winner_q, winner_d;

  logic             key_onehot;
  logic             key_bad;
  logic [CELLS-1:0] act_board;
  logic [CELLS-1:0] atk_shots;
  logic [CELLS-1:0] def_board;

  onehot_check #(.WIDTH(CELLS)) u_key_chk (
    .vec       (key),
    .is_onehot (key_onehot)
  );

  always_comb begin
    key_bad   = key_valid && !key_onehot;
    act_board = (state_q == S_PLACE_P2) ? p2_board_q : p1_board_q;
    atk_shots = (turn_q == P2) ? p2_shots_q : p1_shots_q;
    def_board = (turn_q == P2) ? p1_board_q : p2_board_q;
  end

  always_comb begin
    state_d     = state_q;
    turn_d      = turn_q;
    p1_board_d  = p1_board_q;
    p2_board_d  = p2_board_q;
    p1_shots_d  = p1_shots_q;
    p2_shots_d  = p2_shots_q;
    target_d    = target_q;
    placed_d    = placed_q;
    wait_cnt_d  = wait_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    last_hit_d  = last_hit_q;
    last_miss_d = last_miss_q;
    winner_d    = winner_q;
    err_d       = 1'b0;
    fire_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PLACE_P1;
          turn_d  = P1;
        end
      end

      S_PLACE_P1, S_PLACE_P2: begin
        if (key_valid) begin
          if (key_bad || ((key & act_board) != '0)) begin
            err_d = 1'b1;
          end else begin
            if (state_q == S_PLACE_P1) p1_board_d = p1_board_q | key;
            else                       p2_board_d = p2_board_q | key;
            if (placed_q == PCW'(SHIP_CELLS - 1)) begin
              placed_d = '0;
              if (state_q == S_PLACE_P1) begin
                state_d = S_PLACE_P2;
                turn_d  = P2;
              end else begin
                state_d = S_FIRE_ARM;
                turn_d  = P1;
              end
            end else begin
              placed_d = placed_q + PCW'(1);
            end
          end
        end
      end

      S_FIRE_ARM: begin
        if (key_valid) begin
          if (key_bad || ((key & atk_shots) != '0)) begin
            err_d = 1'b1;
          end else begin
            target_d   = key;
            fire_d     = 1'b1;
            wait_cnt_d = '0;
            state_d    = S_FIRE_WAIT;
            if (turn_q == P2) p2_shots_d = p2_shots_q | key;
            else              p1_shots_d = p1_shots_q | key;
          end
        end
      end

      S_FIRE_WAIT: begin
        // A well-formed key is simply ignored while the datapath is busy.
        err_d = key_bad;
        if (dp_hit || dp_miss) begin
          // Simultaneous hit and miss resolves as a hit.
          last_hit_d  = dp_hit;
          last_miss_d = !dp_hit;
          hold_cnt_d  = '0;
          state_d     = S_RESULT;
          if (turn_q == P2) p1_board_d = dp_new_ships;
          else              p2_board_d = dp_new_ships;
        end else if (wait_cnt_q == WCW'(DP_TIMEOUT - 1)) begin
          // Datapath never answered: refund the shot so the cell can be fired again.
          err_d   = 1'b1;
          state_d = S_FIRE_ARM;
          if (turn_q == P2) p2_shots_d = p2_shots_q & ~target_q;
          else              p1_shots_d = p1_shots_q & ~target_q;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end

      S_RESULT: begin
        if (hold_cnt_q == HCW'(RESULT_HOLD - 1)) begin
          last_hit_d  = 1'b0;
          last_miss_d = 1'b0;
          if (def_board == '0) begin
            state_d  = S_GAME_OVER;
            winner_d = turn_q;
          end else begin
            state_d = S_FIRE_ARM;
            if (!(last_hit_q && EXTRA_TURN_ON_HIT)) turn_d = !turn_q;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end

      S_GAME_OVER: begin
        err_d = key_bad;
        if (start) begin
          state_d    = S_PLACE_P1;
          turn_d     = P1;
          p1_board_d = '0;
          p2_board_d = '0;
          p1_shots_d = '0;
          p2_shots_d = '0;
          target_d   = '0;
          placed_d   = '0;
          winner_d   = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      turn_q      <= 1'b0;
      p1_board_q  <= '0;
      p2_board_q  <= '0;
      p1_shots_q  <= '0;
      p2_shots_q  <= '0;
      target_q    <= '0;
      placed_q    <= '0;
      wait_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      last_hit_q  <= 1'b0;
      last_miss_q <= 1'b0;
      err_q       <= 1'b0;
      fire_q      <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      turn_q      <= turn_d;
      p1_board_q  <= p1_board_d;
      p2_board_q  <= p2_board_d;
      p1_shots_q  <= p1_shots_d;
      p2_shots_q  <= p2_shots_d;
      target_q    <= target_d;
      placed_q    <= placed_d;
      wait_cnt_q  <= wait_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      last_hit_q  <= last_hit_d;
      last_miss_q <= last_miss_d;
      err_q       <= err_d;
      fire_q      <= fire_d;
      winner_q    <= winner_d;
    end
  end

  always_comb begin
    dp_state       = state_code(state_q);
    dp_place       = (state_q == S_PLACE_P1) || (state_q == S_PLACE_P2);
    dp_fire        = fire_q;
    dp_target      = target_q;
    // The defender's board is presented throughout FIRE so it is valid when dp_fire strobes.
    dp_enemy_ships = ((state_q == S_FIRE_ARM) || (state_q == S_FIRE_WAIT)) ? def_board : '0;
    turn           = turn_q;
    p1_board       = p1_board_q;
    p2_board       = p2_board_q;
    p1_shots       = p1_shots_q;
    p2_shots       = p2_shots_q;
    last_hit       = last_hit_q;
    last_miss      = last_miss_q;
    err            = err_q;
    winner_valid   = (state_q == S_GAME_OVER);
    winner         = winner_q;
  end

endmodule
